// File: rtl/mag_sched_pkg.sv
// Shared types and default sizing for the spectrogram magnitude sequencer.
// Saturating output is selected by defining MAG_SCHED_SAT_EN.
package mag_sched_pkg;

  localparam int unsigned DEF_W         = 8;
  localparam int unsigned DEF_FRAME_LEN = 64;
  localparam int unsigned DEF_IDX_W     = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } stateT;

endpackage

// File: rtl/mag_div_seq.sv
// Restoring divider, one quotient bit per cycle, W iterations MSB first.
// The start cycle performs the first iteration; done pulses once the last bit is in.
module mag_div_seq
  import mag_sched_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W:0]     divisor,
  output logic           done,
  output logic [W-1:0]   quotient
);

  localparam int unsigned CNT_W = $clog2(W + 1);

  logic [W:0]       remQ;
  logic [W-1:0]     lowQ;
  logic [CNT_W-1:0] cntQ;

  logic [W:0]   curRem;
  logic         curBit;
  logic [W+1:0] trial;
  logic         fits;
  logic [W:0]   nextRem;

  // The quotient is known to fit in W bits, so the upper dividend half seeds the remainder.
  always_comb begin
    curRem  = start ? {1'b0, dividend[2*W-1:W]} : remQ;
    curBit  = start ? dividend[W-1] : lowQ[W-1];
    trial   = {curRem, curBit};
    fits    = (trial >= {1'b0, divisor});
    nextRem = fits ? (W+1)'(trial - {1'b0, divisor}) : trial[W:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      remQ     <= '0;
      lowQ     <= '0;
      cntQ     <= '0;
      quotient <= '0;
      done     <= 1'b0;
    end else if (start) begin
      remQ     <= nextRem;
      lowQ     <= {dividend[W-2:0], 1'b0};
      quotient <= {{(W-1){1'b0}}, fits};
      cntQ     <= CNT_W'(W - 1);
      done     <= 1'b0;
    end else if (cntQ != '0) begin
      remQ     <= nextRem;
      lowQ     <= {lowQ[W-2:0], 1'b0};
      quotient <= {quotient[W-2:0], fits};
      cntQ     <= cntQ - CNT_W'(1);
      done     <= (cntQ == CNT_W'(1));
    end else begin
      done     <= 1'b0;
    end
  end

endmodule

// File: rtl/mag_sched.sv
// Magnitude sequencer: |z| ~= max + min^2/(2*max) via a shared sequential divider.
// Define MAG_SCHED_SAT_EN to saturate overflowing sums instead of wrapping them.
module mag_sched
  import mag_sched_pkg::*;
#(
  parameter int unsigned W         = DEF_W,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
  parameter int unsigned IDX_W     = DEF_IDX_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_real,
  input  logic [W-1:0]     in_imag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_mag,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  stateT stateQ, stateNext;

  logic [W-1:0]     realQ, realNext;
  logic [W-1:0]     imagQ, imagNext;
  logic [W-1:0]     mxQ, mxNext;
  logic [W-1:0]     quotQ, quotNext;
  logic [W-1:0]     outMagQ, outMagNext;
  logic [IDX_W-1:0] idxQ, idxNext;
  logic             outLastQ, outLastNext;
  logic             outValidQ, outValidNext;
  logic             inReadyQ, inReadyNext;
  logic             busyQ, busyNext;

  logic [W-1:0]   mxC, mnC;
  logic [2*W-1:0] sqC;
  logic [W:0]     dvC;
  logic [W:0]     sumC;
  logic [W-1:0]   magC;
  logic           divStart;
  logic           divDone;
  logic [W-1:0]   divQuot;

  mag_div_seq #(.W(W)) uDiv (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (divStart),
    .dividend (sqC),
    .divisor  (dvC),
    .done     (divDone),
    .quotient (divQuot)
  );

  // Ordering and scaling of the held bin; ties pick the imaginary component.
  always_comb begin
    mxC  = (realQ > imagQ) ? realQ : imagQ;
    mnC  = (realQ > imagQ) ? imagQ : realQ;
    sqC  = (2*W)'(mnC) * (2*W)'(mnC);
    dvC  = {mxC, 1'b0};
    sumC = (W+1)'(mxQ) + (W+1)'(quotQ);
`ifdef MAG_SCHED_SAT_EN
    magC = sumC[W] ? '1 : sumC[W-1:0];
`else
    magC = sumC[W-1:0];
`endif
  end

  always_comb begin
    stateNext    = stateQ;
    realNext     = realQ;
    imagNext     = imagQ;
    mxNext       = mxQ;
    quotNext     = quotQ;
    outMagNext   = outMagQ;
    idxNext      = idxQ;
    outValidNext = outValidQ;
    divStart     = 1'b0;

    case (stateQ)
      IDLE: begin
        if (in_valid && inReadyQ) begin
          realNext  = in_real;
          imagNext  = in_imag;
          stateNext = LOAD;
        end
      end
      LOAD: begin
        mxNext = mxC;
        if (mxC == '0) begin
          quotNext  = '0;
          stateNext = DONE;
        end else begin
          divStart  = 1'b1;
          stateNext = DIV;
        end
      end
      DIV: begin
        if (divDone) begin
          quotNext  = divQuot;
          stateNext = DONE;
        end
      end
      DONE: begin
        // First DONE cycle registers the result; it is then held until accepted.
        if (!outValidQ) begin
          outValidNext = 1'b1;
          outMagNext   = magC;
        end else if (out_ready) begin
          outValidNext = 1'b0;
          idxNext      = (idxQ == LAST_IDX) ? '0 : idxQ + IDX_W'(1);
          stateNext    = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    outLastNext = (idxNext == LAST_IDX);
    inReadyNext = (stateNext == IDLE);
    busyNext    = (stateNext != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stateQ    <= IDLE;
      realQ     <= '0;
      imagQ     <= '0;
      mxQ       <= '0;
      quotQ     <= '0;
      outMagQ   <= '0;
      idxQ      <= '0;
      outLastQ  <= 1'b0;
      outValidQ <= 1'b0;
      inReadyQ  <= 1'b1;
      busyQ     <= 1'b0;
    end else begin
      stateQ    <= stateNext;
      realQ     <= realNext;
      imagQ     <= imagNext;
      mxQ       <= mxNext;
      quotQ     <= quotNext;
      outMagQ   <= outMagNext;
      idxQ      <= idxNext;
      outLastQ  <= outLastNext;
      outValidQ <= outValidNext;
      inReadyQ  <= inReadyNext;
      busyQ     <= busyNext;
    end
  end

  assign in_ready  = inReadyQ;
  assign out_valid = outValidQ;
  assign out_mag   = outMagQ;
  assign out_index = idxQ;
  assign out_last  = outLastQ;
  assign busy      = busyQ;

endmodule

// File: tb/tb_mag_sched.sv
// Scoreboard bench for mag_sched (W=8, FRAME_LEN=4): directed corner bins, then random traffic.
module tb_mag_sched;

  localparam int unsigned W         = 8;
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned IDX_W     = 2;

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_real;
  logic [W-1:0]     in_imag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_mag;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             busy;

  typedef struct {
    int mag;
    int idx;
    int last;
    int lat;
    int acc;
  } expT;

  expT sb[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  accCount = 0;
  int  rdyMode = 0;
  bit  seenValid = 0;

  mag_sched #(.W(W), .FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: max + floor(min^2 / (2*max)), then saturate or wrap to W bits.
  function automatic int refMag(input int re, input int im);
    int mx, mn, s;
    mx = (re > im) ? re : im;
    mn = (re > im) ? im : re;
    s  = (mx == 0) ? 0 : mx + (mn * mn) / (2 * mx);
`ifdef MAG_SCHED_SAT_EN
    if (s > 255) s = 255;
`else
    s = s % 256;
`endif
    return s;
  endfunction

  // Downstream ready pattern: 0 = always, 1 = random, 2 = stalled.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (rdyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic sendBin(input int re, input int im);
    int  waitCyc = 0;
    bit  got = 0;
    expT e;
    @(posedge clock);
    #1;
    in_real  = W'(re);
    in_imag  = W'(im);
    in_valid = 1'b1;
    while (!got && waitCyc < 300) begin
      @(negedge clock);
      if (in_ready) begin
        got   = 1;
        e.mag = refMag(re, im);
        e.idx = accCount % FRAME_LEN;
        e.last = (e.idx == FRAME_LEN - 1) ? 1 : 0;
        e.lat = ((re > im ? re : im) == 0) ? 2 : W + 2;
        e.acc = cyc + 1;
        sb.push_back(e);
        accCount++;
      end else begin
        waitCyc++;
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  // Monitor: every cycle a result is shown it must match the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        if (!seenValid) begin
          seenValid = 1;
          chk("latency", cyc - sb[0].acc, sb[0].lat);
        end
        chk("out_mag", int'(out_mag), sb[0].mag);
        chk("out_index", int'(out_index), sb[0].idx);
        chk("out_last", int'(out_last), sb[0].last);
        chk("in_ready_while_out", int'(in_ready), 0);
        chk("busy_while_out", int'(busy), 1);
        if (out_ready) begin
          sb.delete(0);
          seenValid = 0;
        end
      end
    end
  end

  initial begin
    int n;
    int sel, re, im;
    in_valid = 1'b0;
    in_real  = '0;
    in_imag  = '0;
    reset_n  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_mag", int'(out_mag), 0);
    chk("rst_out_index", int'(out_index), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Back-to-back corner bins; indices run 0,1,2,3,0.
    rdyMode = 0;
    sendBin(3, 4);
    sendBin(0, 0);
    sendBin(6, 0);
    sendBin(0, 11);
    sendBin(200, 200);
    drain();

    // Stalled downstream: result must hold and no new bin may be taken.
    rdyMode = 2;
    sendBin(9, 9);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("hold_valid_seen", int'(out_valid), 1);
    repeat (5) @(negedge clock);
    chk("hold_mag", int'(out_mag), refMag(9, 9));
    rdyMode = 0;
    sendBin(1, 2);
    drain();

    // Reset while the second bin is dividing.
    sendBin(5, 7);
    sendBin(8, 3);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_index", int'(out_index), 0);
    sb.delete();
    accCount  = 0;
    seenValid = 0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    sendBin(7, 7);
    drain();

    // Random traffic with random downstream stalls.
    rdyMode = 1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clock);
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: begin re = int'($urandom_range(0, 255)); im = int'($urandom_range(0, 255)); end
        1: begin re = int'($urandom_range(0, 3));   im = int'($urandom_range(0, 3));   end
        2: begin re = int'($urandom_range(200, 255)); im = int'($urandom_range(200, 255)); end
        default: begin re = int'($urandom_range(0, 255)); im = re; end
      endcase
      sendBin(re, im);
    end
    rdyMode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
